// File: rtl/updown_counter_ctrl_pkg.sv
// Shared definitions for the push-button counter sequencer.
//   state_t   : sequencer states (2-bit encoding)
//   owner_t   : which direction button owns a press/repeat
//   RGB_*     : status LED colours packed as {R,G,B}
//   state_rgb : maps a state to its LED colour
package updown_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_PRESS  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    typedef enum logic {
        OWN_UP = 1'b0,
        OWN_DN = 1'b1
    } owner_t;

    localparam logic [2:0] RGB_OFF    = 3'b100;
    localparam logic [2:0] RGB_IDLE   = 3'b010;
    localparam logic [2:0] RGB_PRESS  = 3'b001;
    localparam logic [2:0] RGB_REPEAT = 3'b011;

    function automatic logic [2:0] state_rgb(input state_t s);
        logic [2:0] colour;
        case (s)
            ST_OFF:    colour = RGB_OFF;
            ST_IDLE:   colour = RGB_IDLE;
            ST_PRESS:  colour = RGB_PRESS;
            default:   colour = RGB_REPEAT;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/updown_counter_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears the history register)
//   level : debounced, synchronised button level
//   rise  : high for the cycle where level is high and was low last cycle
// The history register updates every cycle regardless of sequencer state,
// so a button already held when the sequencer wakes up never produces a rise.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    // One-cycle history of the button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/updown_counter_ctrl.sv
// Push-button sequencer for the board counter.
// Turns debounced UP/DOWN/CLEAR buttons into single steps or auto-repeat
// steps paced by TICK, and drives the RGB status LED from the state.
//   CLK, RST_N          : sole clock, asynchronous active-low reset
//   ON                  : enable switch, low forces OFF and clears the count
//   TICK                : one-cycle repeat-rate enable from the slow divider
//   BTN_UP/BTN_DN/BTN_CLR : debounced button levels, high = pressed
//   CNT                 : counter value, wraps modulo 2**WIDTH
//   WRAP                : one-cycle pulse after a wrapping step
//   R, G, B             : status LED (OFF=R, IDLE=G, PRESS=B, REPEAT=G+B)
module updown_counter_ctrl
    import updown_counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int HOLD_TICKS = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ON,
    input  logic             TICK,
    input  logic             BTN_UP,
    input  logic             BTN_DN,
    input  logic             BTN_CLR,
    output logic [WIDTH-1:0] CNT,
    output logic             WRAP,
    output logic             R,
    output logic             G,
    output logic             B
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;

    logic rise_up, rise_dn, rise_clr;

    state_t             state, state_next;
    owner_t             owner, owner_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [WIDTH-1:0]   cnt_q, cnt_next;
    logic               wrap_q, wrap_next;
    logic               owner_held;
    logic               do_step;
    logic               step_up;

    btn_edge u_edge_up  (.clk(CLK), .rst_n(RST_N), .level(BTN_UP),  .rise(rise_up));
    btn_edge u_edge_dn  (.clk(CLK), .rst_n(RST_N), .level(BTN_DN),  .rise(rise_dn));
    btn_edge u_edge_clr (.clk(CLK), .rst_n(RST_N), .level(BTN_CLR), .rise(rise_clr));

    // State register together with the counter, wrap flag, owner and hold count,
    // so every output changes on the same edge that samples the button or TICK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_OFF;
            owner    <= OWN_UP;
            hold_cnt <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            hold_cnt <= hold_next;
            cnt_q    <= cnt_next;
            wrap_q   <= wrap_next;
        end
    end

    // Next-state logic. Priority: ON low, wake from OFF, CLEAR rise, then the
    // per-state stepping rules. A held CLEAR blocks new presses and TICK steps.
    // Only the owning button is looked at once a press is in progress.
    always_comb begin
        state_next = state;
        owner_next = owner;
        hold_next  = hold_cnt;
        cnt_next   = cnt_q;
        wrap_next  = 1'b0;
        do_step    = 1'b0;
        step_up    = 1'b0;
        owner_held = (owner == OWN_UP) ? BTN_UP : BTN_DN;

        if (!ON) begin
            state_next = ST_OFF;
            cnt_next   = '0;
            hold_next  = '0;
        end else if (state == ST_OFF) begin
            state_next = ST_IDLE;
        end else if (rise_clr) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            hold_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!BTN_CLR && (rise_up ^ rise_dn)) begin
                        do_step    = 1'b1;
                        step_up    = rise_up;
                        owner_next = rise_up ? OWN_UP : OWN_DN;
                        hold_next  = '0;
                        state_next = ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (!owner_held) begin
                        state_next = ST_IDLE;
                    end else if (TICK && !BTN_CLR) begin
                        if (hold_cnt == HOLD_LAST) begin
                            do_step    = 1'b1;
                            step_up    = (owner == OWN_UP);
                            state_next = ST_REPEAT;
                        end else begin
                            hold_next = hold_cnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!owner_held) begin
                        state_next = ST_IDLE;
                    end else if (TICK && !BTN_CLR) begin
                        do_step = 1'b1;
                        step_up = (owner == OWN_UP);
                    end
                end
                default: begin
                    state_next = ST_OFF;
                end
            endcase
        end

        // The wrap flag is judged on the value being stepped away from.
        if (do_step) begin
            if (step_up) begin
                cnt_next  = cnt_q + 1'b1;
                wrap_next = (cnt_q == CNT_MAX);
            end else begin
                cnt_next  = cnt_q - 1'b1;
                wrap_next = (cnt_q == '0);
            end
        end
    end

    // Output decode: the LED colour is a pure function of the state register.
    always_comb begin
        {R, G, B} = state_rgb(state);
    end

    assign CNT  = cnt_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Self-checking bench for updown_counter_ctrl (WIDTH=3, HOLD_TICKS=4, TICK every 10 CLK).
// Each driven cycle runs a reference model whose expected outputs are queued
// and then compared against the DUT just after the clock edge.
module tb_updown_counter_ctrl;

    localparam int WIDTH       = 3;
    localparam int HOLD_TICKS  = 4;
    localparam int TICK_PERIOD = 10;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             ON;
    logic             TICK;
    logic             BTN_UP;
    logic             BTN_DN;
    logic             BTN_CLR;
    logic [WIDTH-1:0] CNT;
    logic             WRAP;
    logic             R, G, B;

    updown_counter_ctrl #(.WIDTH(WIDTH), .HOLD_TICKS(HOLD_TICKS)) dut (
        .CLK(CLK), .RST_N(RST_N), .ON(ON), .TICK(TICK),
        .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_CLR(BTN_CLR),
        .CNT(CNT), .WRAP(WRAP), .R(R), .G(G), .B(B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             wrap;
        logic [2:0]       rgb;
    } expect_t;

    expect_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cycleNum = 0;

    // Reference model state: 0=OFF 1=IDLE 2=PRESS 3=REPEAT
    int               mState;
    logic [WIDTH-1:0] mCnt;
    logic             mWrap;
    int               mHold;
    bit               mOwnUp;
    bit               mHistUp, mHistDn, mHistClr;

    function automatic logic [2:0] colourOf(input int s);
        case (s)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cycleNum, observed, expected);
        end
    endtask

    function automatic void modelReset();
        mState   = 0;
        mCnt     = '0;
        mWrap    = 1'b0;
        mHold    = 0;
        mOwnUp   = 1'b1;
        mHistUp  = 1'b0;
        mHistDn  = 1'b0;
        mHistClr = 1'b0;
    endfunction

    function automatic void modelStep(input bit on, input bit up, input bit dn, input bit clr, input bit tick);
        bit rUp, rDn, rClr, ownHeld, stepReq, stepDirUp;
        rUp       = up  && !mHistUp;
        rDn       = dn  && !mHistDn;
        rClr      = clr && !mHistClr;
        ownHeld   = mOwnUp ? up : dn;
        stepReq   = 1'b0;
        stepDirUp = 1'b0;
        mWrap     = 1'b0;

        if (!on) begin
            mState = 0;
            mCnt   = '0;
            mHold  = 0;
        end else if (mState == 0) begin
            mState = 1;
        end else if (rClr) begin
            mState = 1;
            mCnt   = '0;
            mHold  = 0;
        end else if (mState == 1) begin
            if (!clr && (rUp != rDn)) begin
                stepReq   = 1'b1;
                stepDirUp = rUp;
                mOwnUp    = rUp;
                mHold     = 0;
                mState    = 2;
            end
        end else if (!ownHeld) begin
            mState = 1;
        end else if (tick && !clr) begin
            if (mState == 3) begin
                stepReq   = 1'b1;
                stepDirUp = mOwnUp;
            end else if (mHold == HOLD_TICKS - 1) begin
                stepReq   = 1'b1;
                stepDirUp = mOwnUp;
                mState    = 3;
            end else begin
                mHold++;
            end
        end

        if (stepReq) begin
            if (stepDirUp) begin
                mWrap = (mCnt == 3'd7);
                mCnt  = mCnt + 3'd1;
            end else begin
                mWrap = (mCnt == 3'd0);
                mCnt  = mCnt - 3'd1;
            end
        end

        mHistUp  = up;
        mHistDn  = dn;
        mHistClr = clr;
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), queue the
    // model's prediction, then compare the DUT just after the rising edge.
    task automatic applyStimulus(input bit on, input bit up, input bit dn, input bit clr);
        expect_t e, got;
        bit tick;
        tick    = ((cycleNum % TICK_PERIOD) == TICK_PERIOD - 1);
        ON      = on;
        BTN_UP  = up;
        BTN_DN  = dn;
        BTN_CLR = clr;
        TICK    = tick;
        modelStep(on, up, dn, clr, tick);
        e.cnt  = mCnt;
        e.wrap = mWrap;
        e.rgb  = colourOf(mState);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        checkOutput("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            checkOutput("cnt",  32'(CNT),        32'(got.cnt));
            checkOutput("wrap", 32'(WRAP),       32'(got.wrap));
            checkOutput("rgb",  32'({R, G, B}),  32'(got.rgb));
        end
        cycleNum++;
        @(negedge CLK);
    endtask

    task automatic holdFor(input int n, input bit on, input bit up, input bit dn, input bit clr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(on, up, dn, clr);
        end
    endtask

    // Asynchronous reset asserted between edges, checked immediately, released on a falling edge.
    task automatic resetPulse();
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("rst_cnt",  32'(CNT),       32'd0);
        checkOutput("rst_wrap", 32'(WRAP),      32'd0);
        checkOutput("rst_rgb",  32'({R, G, B}), 32'b100);
        modelReset();
        @(negedge CLK);
        cycleNum++;
        @(negedge CLK);
        cycleNum++;
        RST_N = 1'b1;
    endtask

    initial begin
        bit rOn, rUp, rDn, rClr;

        RST_N   = 1'b0;
        ON      = 1'b0;
        TICK    = 1'b0;
        BTN_UP  = 1'b0;
        BTN_DN  = 1'b0;
        BTN_CLR = 1'b0;
        modelReset();
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("init_cnt", 32'(CNT),       32'd0);
        checkOutput("init_rgb", 32'({R, G, B}), 32'b100);
        RST_N = 1'b1;

        // Power on, then three short UP taps: three single steps, no repeat.
        holdFor(3, 1, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            holdFor(15, 1, 1, 0, 0);
            holdFor(5, 1, 0, 0, 0);
        end
        checkOutput("taps_cnt", 32'(CNT), 32'd3);

        // Climb to 7, then wrap up to 0 and back down to 7.
        for (int t = 0; t < 4; t++) begin
            holdFor(5, 1, 1, 0, 0);
            holdFor(4, 1, 0, 0, 0);
        end
        checkOutput("climb_cnt", 32'(CNT), 32'd7);
        holdFor(5, 1, 1, 0, 0);
        holdFor(4, 1, 0, 0, 0);
        holdFor(5, 1, 0, 1, 0);
        holdFor(4, 1, 0, 0, 0);
        checkOutput("wrapdn_cnt", 32'(CNT), 32'd7);

        // Clear, then hold UP long enough to enter auto-repeat.
        holdFor(2, 1, 0, 0, 1);
        holdFor(3, 1, 0, 0, 0);
        holdFor(90, 1, 1, 0, 0);
        checkOutput("repeat_rgb", 32'({R, G, B}), 32'b011);
        holdFor(3, 1, 0, 0, 0);

        // Reset in the middle of a repeat while UP stays held: no step afterwards.
        holdFor(70, 1, 1, 0, 0);
        resetPulse();
        holdFor(3, 1, 1, 0, 0);
        checkOutput("post_rst_rgb", 32'({R, G, B}), 32'b010);
        checkOutput("post_rst_cnt", 32'(CNT),       32'd0);
        holdFor(3, 1, 0, 0, 0);

        // UP and DN rising together: no step. Then DN pressed during an UP hold is ignored.
        holdFor(6, 1, 1, 1, 0);
        holdFor(3, 1, 0, 0, 0);
        holdFor(4, 1, 1, 0, 0);
        holdFor(30, 1, 1, 1, 0);
        holdFor(8, 1, 0, 1, 0);
        holdFor(3, 1, 0, 0, 0);

        // CLEAR rising on a TICK cycle during repeat: clear wins.
        holdFor(3, 1, 0, 0, 1);
        holdFor(3, 1, 0, 0, 0);
        holdFor(60, 1, 1, 0, 0);
        while ((cycleNum % TICK_PERIOD) != TICK_PERIOD - 1) begin
            applyStimulus(1, 1, 0, 0);
        end
        applyStimulus(1, 1, 0, 1);
        checkOutput("clr_cnt", 32'(CNT),       32'd0);
        checkOutput("clr_rgb", 32'({R, G, B}), 32'b010);
        holdFor(25, 1, 1, 1, 1);
        holdFor(2, 1, 0, 0, 0);

        // ON low while UP is held.
        holdFor(45, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("off_cnt", 32'(CNT),       32'd0);
        checkOutput("off_rgb", 32'({R, G, B}), 32'b100);
        holdFor(4, 1, 1, 0, 0);
        holdFor(3, 1, 0, 0, 0);

        // Random button activity.
        rOn = 1'b1; rUp = 1'b0; rDn = 1'b0; rClr = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0)   rUp  = ~rUp;
            if ($urandom_range(0, 9) == 0)   rDn  = ~rDn;
            if ($urandom_range(0, 39) == 0)  rClr = ~rClr;
            rOn = ($urandom_range(0, 99) != 0);
            applyStimulus(rOn, rUp, rDn, rClr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
